// File: rtl/timer_bank_if.sv
// Byte-wide CPU I/O bus view of the timer bank: register access plus tick/irq outputs.
interface timer_bank_if #(parameter int AW = 4);
  logic [AW-1:0] addr;
  logic [7:0]    di;
  logic          wren;
  logic          rden;
  logic [7:0]    q;
  logic          tick;
  logic          irq;

  modport master (output addr, di, wren, rden, input q, tick, irq);
  modport slave  (input addr, di, wren, rden, output q, tick, irq);
endinterface

// File: rtl/timer_bank.sv
// Multi-channel down-counter timer bank: shared prescaler tick, per-channel
// one-shot/auto-reload counters with sticky flags and a combined interrupt.
module timer_chan #(
  parameter int CNTW = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       wr,
  input  logic [1:0] reg_sel,
  input  logic [7:0] di,
  output logic [7:0] rd_data,
  output logic       irq
);
  logic [CNTW-1:0] count_q, count_d, reload_q, reload_d;
  logic [7:0]      stage_q, stage_d;
  logic [2:0]      ctrl_q, ctrl_d;     // {irqen, autoreload, en}
  logic            flag_q, flag_d;
  logic [15:0]     wr_val, cnt_ext;
  logic            active, expire;

  always_comb begin
    wr_val   = {di, stage_q};
    cnt_ext  = 16'(count_q);
    active   = tick && ctrl_q[0] && (count_q != '0);
    count_d  = count_q;
    reload_d = reload_q;
    stage_d  = stage_q;
    ctrl_d   = ctrl_q;
    flag_d   = flag_q;
    expire   = 1'b0;
    // A HI write takes priority over a coincident tick; that tick is dropped.
    if (wr && reg_sel == 2'd1) begin
      count_d  = wr_val[CNTW-1:0];
      reload_d = wr_val[CNTW-1:0];
    end else if (active) begin
      if (count_q == CNTW'(1)) begin
        expire  = 1'b1;
        count_d = (ctrl_q[1] && reload_q != '0) ? reload_q : '0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
    if (wr && reg_sel == 2'd0) stage_d = di;
    if (wr && reg_sel == 2'd2) ctrl_d = di[2:0];
    if (wr && reg_sel == 2'd3 && di[0]) flag_d = 1'b0;
    if (expire) flag_d = 1'b1;
    rd_data = 8'h00;
    case (reg_sel)
      2'd0:    rd_data = cnt_ext[7:0];
      2'd1:    rd_data = cnt_ext[15:8];
      2'd2:    rd_data = {5'b0, ctrl_q};
      default: rd_data = {6'b0, count_q != '0, flag_q};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      stage_q  <= '0;
      ctrl_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      stage_q  <= stage_d;
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
    end
  end

  assign irq = flag_q & ctrl_q[2];
endmodule

module timer_bank #(
  parameter int MCLKFREQ = 24000000,
  parameter int TICKHZ   = 100,
  parameter int NCHAN    = 4,
  parameter int CNTW     = 16
) (
  input logic        clk,
  input logic        reset,
  timer_bank_if.slave bus
);
  localparam int PDIV = MCLKFREQ / TICKHZ;
  localparam int PW   = $clog2(PDIV);
  localparam int AW   = $clog2(NCHAN) + 2;

  logic [PW-1:0]              pre_q, pre_d;
  logic                       tick_q, tick_d;
  logic [7:0]                 rdata_q, rdata_d;
  logic [AW-1:0]              ch_idx;
  logic [NCHAN-1:0]           ch_wr, ch_irq;
  logic [NCHAN-1:0][7:0]      ch_rd;

  // pre_q counts up; reaching PDIV-1 is the terminal state, so the registered
  // tick lands PDIV clocks after reset release.
  always_comb begin
    tick_d = (pre_q == PW'(PDIV - 1));
    pre_d  = tick_d ? '0 : pre_q + 1'b1;
    ch_idx = bus.addr >> 2;
    for (int i = 0; i < NCHAN; i++) ch_wr[i] = bus.wren && (ch_idx == AW'(i));
    rdata_d = rdata_q;
    if (bus.rden) begin
      for (int i = 0; i < NCHAN; i++)
        if (ch_idx == AW'(i)) rdata_d = ch_rd[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      rdata_q <= rdata_d;
    end
  end

  timer_chan #(.CNTW(CNTW)) u_chan [NCHAN-1:0] (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick_q),
    .wr      (ch_wr),
    .reg_sel (bus.addr[1:0]),
    .di      (bus.di),
    .rd_data (ch_rd),
    .irq     (ch_irq)
  );

  assign bus.q    = rdata_q;
  assign bus.tick = tick_q;
  assign bus.irq  = |ch_irq;
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register table plus tick-aligned corner sequences.
module tb_timer_bank;
  localparam int PDIV = 240;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc;
  int   checks = 0;
  int   errs   = 0;

  timer_bank_if #(.AW(4)) bus ();

  timer_bank #(.MCLKFREQ(24000), .TICKHZ(100), .NCHAN(4), .CNTW(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.addr = a; bus.di = d; bus.wren = 1'b1;
    @(negedge clk);
    bus.wren = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    bus.addr = a; bus.rden = 1'b1;
    @(negedge clk);
    bus.rden = 1'b0;
    v = bus.q;
  endtask

  task automatic rdchk(input string nm, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(nm, v, exp);
  endtask

  // Returns at the negedge where tick is high; a write issued now coincides with it.
  task automatic wait_tick_hi();
    int n = 0;
    @(negedge clk);
    while (bus.tick !== 1'b1 && n < 3*PDIV) begin
      @(negedge clk);
      n++;
    end
    if (bus.tick !== 1'b1) begin
      checks++; errs++;
      $display("FAIL tick_timeout: got no tick expected tick within %0d cycles", 3*PDIV);
    end
  endtask

  task automatic tick_done();
    wait_tick_hi();
    @(negedge clk);
  endtask

  initial begin
    int nt;
    tbl[0]  = '{1'b1, 4'd4,  8'h34, 8'h00};
    tbl[1]  = '{1'b1, 4'd5,  8'h12, 8'h00};
    tbl[2]  = '{1'b0, 4'd4,  8'h00, 8'h34};
    tbl[3]  = '{1'b0, 4'd5,  8'h00, 8'h12};
    tbl[4]  = '{1'b1, 4'd6,  8'hFE, 8'h00};
    tbl[5]  = '{1'b0, 4'd6,  8'h00, 8'h06};
    tbl[6]  = '{1'b0, 4'd7,  8'h00, 8'h02};
    tbl[7]  = '{1'b1, 4'd4,  8'h99, 8'h00};
    tbl[8]  = '{1'b0, 4'd4,  8'h00, 8'h34};
    tbl[9]  = '{1'b0, 4'd5,  8'h00, 8'h12};
    tbl[10] = '{1'b0, 4'd10, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 4'd3,  8'h00, 8'h00};

    bus.addr = '0; bus.di = '0; bus.wren = 1'b0; bus.rden = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_q", bus.q, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_irq", bus.irq, 0);
    rst = 1'b0;

    // Prescaler: ticks at 240, 480, 720, one clock wide
    nt = 0;
    for (int n = 0; n < 3*PDIV + 5; n++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        chk($sformatf("tick%0d_cycle", nt), cyc, (nt + 1) * PDIV);
        nt++;
      end
    end
    chk("tick_count", nt, 3);

    // Register table on ch1 (disabled, so ticks cannot interfere)
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else rdchk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end
    chk("tbl_irq", bus.irq, 0);

    // Ch0 one-shot with irq
    wr(0, 8'h03); wr(1, 8'h00); wr(2, 8'h05);
    rdchk("os_cnt3", 0, 8'h03);
    tick_done(); rdchk("os_cnt2", 0, 8'h02); chk("os_irq_t1", bus.irq, 0);
    tick_done(); rdchk("os_cnt1", 0, 8'h01); rdchk("os_stat_t2", 3, 8'h02);
    tick_done(); rdchk("os_cnt0", 0, 8'h00); rdchk("os_stat_t3", 3, 8'h01);
    chk("os_irq_t3", bus.irq, 1);
    wr(3, 8'h01); chk("os_irq_w1c", bus.irq, 0);
    tick_done(); rdchk("os_idle", 3, 8'h00);

    // Ch1 auto-reload period 2
    wr(4, 8'h02); wr(5, 8'h00); wr(6, 8'h07);
    tick_done(); rdchk("ar_t1_cnt", 4, 8'h01); rdchk("ar_t1_stat", 7, 8'h02);
    tick_done(); rdchk("ar_t2_cnt", 4, 8'h02); rdchk("ar_t2_stat", 7, 8'h03);
    chk("ar_t2_irq", bus.irq, 1);
    wr(7, 8'h01); chk("ar_w1c_irq", bus.irq, 0);
    tick_done(); rdchk("ar_t3_cnt", 4, 8'h01); rdchk("ar_t3_stat", 7, 8'h02);
    tick_done(); rdchk("ar_t4_cnt", 4, 8'h02); rdchk("ar_t4_stat", 7, 8'h03);
    wr(7, 8'h01);
    tick_done(); rdchk("ar_t5_cnt", 4, 8'h01);
    tick_done(); rdchk("ar_t6_stat", 7, 8'h03);
    wr(6, 8'h00); wr(7, 8'h01);
    chk("ar_off_irq", bus.irq, 0);

    // Ch2: HI write coincident with tick wins
    wr(8, 8'h05); wr(9, 8'h00); wr(10, 8'h01); wr(8, 8'h10);
    wait_tick_hi(); wr(9, 8'h00);
    rdchk("hi_tick_lo", 8, 8'h10); rdchk("hi_tick_hi", 9, 8'h00);
    tick_done(); rdchk("hi_tick_next", 8, 8'h0F);
    wr(10, 8'h00);

    // Ch3: en freeze/resume
    wr(12, 8'h04); wr(13, 8'h00); wr(14, 8'h01);
    tick_done(); rdchk("frz_run", 12, 8'h03);
    wr(14, 8'h00);
    tick_done(); rdchk("frz_hold", 12, 8'h03);
    wr(14, 8'h01);
    tick_done(); rdchk("frz_resume", 12, 8'h02);

    // Ch3: W1C coincident with expiry keeps flag
    wr(12, 8'h02); wr(13, 8'h00); wr(14, 8'h05);
    tick_done(); rdchk("w1c_pre_stat", 15, 8'h02);
    wait_tick_hi(); wr(15, 8'h01);
    rdchk("w1c_race_stat", 15, 8'h01); chk("w1c_race_irq", bus.irq, 1);
    wr(15, 8'h01); rdchk("w1c_clr_stat", 15, 8'h00); chk("w1c_clr_irq", bus.irq, 0);
    wr(14, 8'h00);

    // Reset mid-count with irq pending
    wr(0, 8'h01); wr(1, 8'h00);
    tick_done(); chk("pre_rst_irq", bus.irq, 1);
    wr(0, 8'h23); wr(1, 8'h01);
    rdchk("pre_rst_hi", 1, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q", bus.q, 0);
    chk("mid_rst_irq", bus.irq, 0);
    chk("mid_rst_tick", bus.tick, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    rdchk("post_rst_lo", 0, 8'h00);
    rdchk("post_rst_hi", 1, 8'h00);
    rdchk("post_rst_stat", 3, 8'h00);
    wait_tick_hi();
    chk("post_rst_tick_cycle", cyc, PDIV);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
